pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_if.sv | 38 +++
 rtl/pipe_hazard_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard unit.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_re1;
  logic        id_re2;
  logic        id_rf_we;
  logic [4:0]  id_wR;
  logic        id_is_load;
  logic        ex_redirect;
  logic [31:0] ex_wD;
  logic [31:0] mem_wD;
  logic [31:0] wb_wD;
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        rd1_op;
  logic        rd2_op;
  logic [31:0] rd1_f;
  logic [31:0] rd2_f;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport slave (
    input  id_rs1, id_rs2, id_re1, id_re2, id_rf_we, id_wR, id_is_load,
    input  ex_redirect, ex_wD, mem_wD, wb_wD,
    output pc_stall, if_id_stall, if_id_flush, id_ex_flush,
    output rd1_op, rd2_op, rd1_f, rd2_f, stall_cnt, flush_cnt
  );

  modport master (
    output id_rs1, id_rs2, id_re1, id_re2, id_rf_we, id_wR, id_is_load,
    output ex_redirect, ex_wD, mem_wD, wb_wD,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_flush,
    input  rd1_op, rd2_op, rd1_f, rd2_f, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard unit: tracks in-flight destinations for EX/MEM/WB,
// resolves load-use stalls and redirect flushes, and selects forwarded operands.
module pipe_hazard_ctrl (
  input logic              clk,
  input logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  logic        r_ex_we;
  logic [4:0]  r_ex_wr;
  logic        r_ex_ld;
  logic        r_mem_we;
  logic [4:0]  r_mem_wr;
  logic        r_wb_we;
  logic [4:0]  r_wb_wr;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic w_ex_m1, w_ex_m2, w_mem_m1, w_mem_m2, w_wb_m1, w_wb_m2;
  logic w_ex_fwd1, w_ex_fwd2;
  logic w_lu;
  logic w_stall_act;
  logic w_id_ex_flush;
  logic w_op1, w_op2;

  // x0 is excluded here so it can neither forward nor stall.
  assign w_ex_m1  = r_ex_we  && (r_ex_wr  == hz.id_rs1) && (hz.id_rs1 != 5'd0) && hz.id_re1;
  assign w_ex_m2  = r_ex_we  && (r_ex_wr  == hz.id_rs2) && (hz.id_rs2 != 5'd0) && hz.id_re2;
  assign w_mem_m1 = r_mem_we && (r_mem_wr == hz.id_rs1) && (hz.id_rs1 != 5'd0) && hz.id_re1;
  assign w_mem_m2 = r_mem_we && (r_mem_wr == hz.id_rs2) && (hz.id_rs2 != 5'd0) && hz.id_re2;
  assign w_wb_m1  = r_wb_we  && (r_wb_wr  == hz.id_rs1) && (hz.id_rs1 != 5'd0) && hz.id_re1;
  assign w_wb_m2  = r_wb_we  && (r_wb_wr  == hz.id_rs2) && (hz.id_rs2 != 5'd0) && hz.id_re2;

  // A load in EX has no data yet, so its match can only stall, never forward.
  assign w_ex_fwd1 = w_ex_m1 && !r_ex_ld;
  assign w_ex_fwd2 = w_ex_m2 && !r_ex_ld;

  assign w_lu          = (w_ex_m1 || w_ex_m2) && r_ex_ld;
  assign w_stall_act   = w_lu && !hz.ex_redirect;
  assign w_id_ex_flush = hz.ex_redirect || w_lu;

  assign w_op1 = !w_lu && (w_ex_fwd1 || w_mem_m1 || w_wb_m1);
  assign w_op2 = !w_lu && (w_ex_fwd2 || w_mem_m2 || w_wb_m2);

  // Control outputs; redirect overrides the load-use stall.
  always_comb begin
    hz.pc_stall    = w_stall_act;
    hz.if_id_stall = w_stall_act;
    hz.if_id_flush = hz.ex_redirect;
    hz.id_ex_flush = w_id_ex_flush;
  end

  // Forward mux, youngest producer first; zero when nothing is forwarded.
  always_comb begin
    hz.rd1_op = w_op1;
    hz.rd2_op = w_op2;
    hz.rd1_f  = 32'd0;
    hz.rd2_f  = 32'd0;
    if (w_op1) begin
      if (w_ex_fwd1)     hz.rd1_f = hz.ex_wD;
      else if (w_mem_m1) hz.rd1_f = hz.mem_wD;
      else               hz.rd1_f = hz.wb_wD;
    end
    if (w_op2) begin
      if (w_ex_fwd2)     hz.rd2_f = hz.ex_wD;
      else if (w_mem_m2) hz.rd2_f = hz.mem_wD;
      else               hz.rd2_f = hz.wb_wD;
    end
  end

  // Shadow destination pipeline; a flushed EX slot becomes a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_we  <= 1'b0;
      r_ex_wr  <= 5'd0;
      r_ex_ld  <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_wr <= 5'd0;
      r_wb_we  <= 1'b0;
      r_wb_wr  <= 5'd0;
    end else begin
      if (w_id_ex_flush) begin
        r_ex_we <= 1'b0;
        r_ex_wr <= 5'd0;
        r_ex_ld <= 1'b0;
      end else begin
        r_ex_we <= hz.id_rf_we;
        r_ex_wr <= hz.id_wR;
        r_ex_ld <= hz.id_is_load;
      end
      r_mem_we <= r_ex_we;
      r_mem_wr <= r_ex_wr;
      r_wb_we  <= r_mem_we;
      r_wb_wr  <= r_mem_wr;
    end
  end

  // Saturating event counters; a stall that coincides with a redirect is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_stall_act && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (hz.ex_redirect && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign hz.stall_cnt = r_stall_cnt;
  assign hz.flush_cnt = r_flush_cnt;

endmodule
